// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the unified instruction/data memory port:
// default bus widths, requester ids and arbiter state encoding.
package cpu_mem_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 12;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_wait_ctr.sv
// Saturating memory-wait counter; tc flags the enabled cycle whose increment
// brings the count to TIMEOUT_CYC, so the caller can abort on that same edge.
module mem_wait_ctr #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] TOP  = 8'(TIMEOUT_CYC);
    localparam logic [7:0] LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != TOP)) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tc = en && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between fetch (I) and
// load/store (D); registered memory request with timeout, combinational stall.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              stall,
    output logic              err
);

    arb_state_t state_q, state_d;
    logic       last_grant;
    logic       pend_i, pend_d;
    logic       grant, grant_port;
    logic       busy, done, timeout;
    logic       ctr_tc;

    // A port being acked this cycle is already served, so it must not win again.
    assign pend_i = i_req & ~i_ack;
    assign pend_d = d_req & ~d_ack;
    assign busy   = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign stall  = pend_i | pend_d;

    mem_wait_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_ctr (
        .clk (clk),
        .rst (rst),
        .clr (grant),
        .en  (busy & ~m_ack),
        .tc  (ctr_tc)
    );

    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        grant_port = PORT_I;
        done       = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_i || pend_d) begin
                    grant = 1'b1;
                    if (pend_i && pend_d) begin
                        grant_port = ~last_grant;
                    end else begin
                        grant_port = pend_d ? PORT_D : PORT_I;
                    end
                    state_d = (grant_port == PORT_D) ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ack) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (ctr_tc) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_grant <= PORT_I;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q <= state_d;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            err     <= 1'b0;
            if (grant) begin
                m_req      <= 1'b1;
                m_we       <= (grant_port == PORT_D) & d_we;
                m_addr     <= (grant_port == PORT_D) ? d_addr : i_addr;
                last_grant <= grant_port;
                if (grant_port == PORT_D) begin
                    m_wdata <= d_wdata;
                end
            end
            if (done || timeout) begin
                m_req <= 1'b0;
                m_we  <= 1'b0;
                err   <= timeout;
                if (state_q == BUSY_I) begin
                    i_ack   <= 1'b1;
                    i_rdata <= timeout ? '0 : m_rdata;
                end else begin
                    d_ack <= 1'b1;
                    // Stores leave the last load value visible unless aborted.
                    if (timeout) begin
                        d_rdata <= '0;
                    end else if (!m_we) begin
                        d_rdata <= m_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory model.
module tb_mem_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;
    logic          stall;
    logic          err;

    int checks = 0;
    int failures = 0;

    int          mcnt = 0;
    int          mem_lat = 1;
    bit          mem_en = 1'b1;
    bit          use_fixed = 1'b0;
    logic [DW-1:0] fixed_rd = '0;
    logic [DW-1:0] i_rd_m = '0;
    logic [DW-1:0] d_rd_m = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .stall(stall), .err(err)
    );

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return {a[3:0], a} ^ 16'h3C5A;
    endfunction

    // Memory acks in the mem_lat-th cycle of m_req.
    always @(posedge clk) begin
        if (!m_req || m_ack) mcnt <= 0;
        else                 mcnt <= mcnt + 1;
    end
    assign m_ack   = mem_en && m_req && (mcnt == mem_lat - 1);
    assign m_rdata = use_fixed ? fixed_rd : mem_fn(m_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One isolated transaction, entered and left at a falling edge.
    task automatic xact(input string tag, input bit is_d, input bit we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int cyc;
        int mack_cyc;
        int stall_n;
        bit done;
        bit saw;
        logic [AW-1:0] s_addr;
        logic          s_we;
        logic [DW-1:0] s_wd;
        logic [DW-1:0] exp_rd;
        cyc = 0; mack_cyc = -1; stall_n = 0; done = 1'b0; saw = 1'b0;
        s_addr = '0; s_we = 1'b0; s_wd = '0;
        exp_rd = use_fixed ? fixed_rd : mem_fn(addr);
        if (is_d) begin
            d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            i_addr = addr; i_req = 1'b1;
        end
        #1;
        while (!done && cyc < 40) begin
            if (stall) stall_n++;
            if (m_req && !saw) begin
                saw = 1'b1; s_addr = m_addr; s_we = m_we; s_wd = m_wdata;
            end
            if (m_ack) mack_cyc = cyc;
            @(negedge clk);
            cyc++;
            if (i_ack || d_ack) done = 1'b1;
        end
        chk({tag, "_acked"}, 32'(done), 1);
        chk({tag, "_ack_port"}, {30'd0, i_ack, d_ack}, is_d ? 32'd1 : 32'd2);
        chk({tag, "_latency"}, 32'(cyc), 32'(mem_lat + 1));
        chk({tag, "_ack_after_mack"}, 32'(mack_cyc), 32'(cyc - 1));
        chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(mem_lat + 1));
        chk({tag, "_m_addr"}, 32'(s_addr), 32'(addr));
        chk({tag, "_m_we"}, 32'(s_we), 32'(is_d & we));
        chk({tag, "_err"}, 32'(err), 0);
        if (is_d && we) begin
            chk({tag, "_m_wdata"}, 32'(s_wd), 32'(wdata));
            chk({tag, "_d_rdata_kept"}, 32'(d_rdata), 32'(d_rd_m));
        end else if (is_d) begin
            d_rd_m = exp_rd;
            chk({tag, "_d_rdata"}, 32'(d_rdata), 32'(d_rd_m));
        end else begin
            i_rd_m = exp_rd;
            chk({tag, "_i_rdata"}, 32'(i_rdata), 32'(i_rd_m));
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_pulse_1cyc"}, {30'd0, i_ack, d_ack}, 0);
    endtask

    initial begin
        int n_req;
        int cyc;
        int bad;
        bit done;

        // Reset state
        #3;
        chk("rst_m_req", 32'(m_req), 0);
        chk("rst_acks_err", {29'd0, i_ack, d_ack, err}, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        chk("rst_m_bus", {3'd0, m_we, m_addr, m_wdata}, 0);
        chk("rst_stall", 32'(stall), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single fetch, memory acks in the first m_req cycle
        use_fixed = 1'b1; fixed_rd = 16'hA5C3; mem_lat = 1;
        xact("fetch1", 1'b0, 1'b0, 12'h010, 16'h0000);
        chk("fetch1_rdata_held", 32'(i_rdata), 32'h0000A5C3);
        use_fixed = 1'b0;

        // Simultaneous requests: D wins first after reset, then I
        i_addr = 12'h020; i_req = 1'b1;
        d_addr = 12'h200; d_we = 1'b0; d_req = 1'b1;
        @(negedge clk);
        chk("both1_first_addr", 32'(m_addr), 32'h200);
        chk("both1_first_req", 32'(m_req), 1);
        @(negedge clk);
        chk("both1_d_ack", {30'd0, i_ack, d_ack}, 1);
        d_rd_m = mem_fn(12'h200);
        chk("both1_d_rdata", 32'(d_rdata), 32'(d_rd_m));
        d_req = 1'b0;
        @(negedge clk);
        chk("both1_second_addr", 32'(m_addr), 32'h020);
        chk("both1_second_req", {30'd0, m_req, i_ack | d_ack}, 2);
        @(negedge clk);
        chk("both1_i_ack", {30'd0, i_ack, d_ack}, 2);
        i_rd_m = mem_fn(12'h020);
        chk("both1_i_rdata", 32'(i_rdata), 32'(i_rd_m));
        i_req = 1'b0;
        @(negedge clk);

        // Leave last_grant at D, then contend again: I must win
        xact("dload1", 1'b1, 1'b0, 12'h201, 16'h0000);
        i_addr = 12'h030; i_req = 1'b1;
        d_addr = 12'h202; d_we = 1'b0; d_req = 1'b1;
        @(negedge clk);
        chk("both2_first_addr", 32'(m_addr), 32'h030);
        @(negedge clk);
        chk("both2_i_ack", {30'd0, i_ack, d_ack}, 2);
        i_rd_m = mem_fn(12'h030);
        chk("both2_i_rdata", 32'(i_rdata), 32'(i_rd_m));
        i_req = 1'b0;
        @(negedge clk);
        chk("both2_second_addr", 32'(m_addr), 32'h202);
        @(negedge clk);
        chk("both2_d_ack", {30'd0, i_ack, d_ack}, 1);
        d_rd_m = mem_fn(12'h202);
        chk("both2_d_rdata", 32'(d_rdata), 32'(d_rd_m));
        d_req = 1'b0;
        @(negedge clk);

        // Store leaves d_rdata untouched
        xact("store1", 1'b1, 1'b1, 12'h0FF, 16'h1234);

        // Timeout: memory never answers
        mem_en = 1'b0;
        i_addr = 12'h055; i_req = 1'b1;
        n_req = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (i_ack || d_ack) done = 1'b1;
            else if (m_req) n_req++;
        end
        chk("to_acked", 32'(done), 1);
        chk("to_wait_cycles", 32'(n_req), 15);
        chk("to_i_ack_err", {29'd0, i_ack, d_ack, err}, 3'b101);
        chk("to_i_rdata_zero", 32'(i_rdata), 0);
        chk("to_m_req_low", 32'(m_req), 0);
        i_rd_m = '0;
        i_req = 1'b0;
        @(negedge clk);
        chk("to_err_pulse", 32'(err), 0);
        mem_en = 1'b1;
        xact("after_to", 1'b1, 1'b0, 12'h123, 16'h0000);

        // Reset while BUSY_D
        mem_en = 1'b0;
        d_addr = 12'h300; d_we = 1'b0; d_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rbusy_m_req", {30'd0, m_req, stall}, 3);
        #2;
        rst = 1'b1;
        d_req = 1'b0;
        #1;
        chk("rbusy_async_m_req", 32'(m_req), 0);
        chk("rbusy_stall", 32'(stall), 0);
        chk("rbusy_outputs", {i_rdata, d_rdata}, 0);
        chk("rbusy_m_addr", 32'(m_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        mem_en = 1'b1;
        d_rd_m = '0; i_rd_m = '0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (i_ack || d_ack || err || m_req) bad++;
        end
        chk("rbusy_silent_after", 32'(bad), 0);

        // Alternating I/D stream, 3-cycle memory
        mem_lat = 3;
        for (int k = 0; k < 20; k++) begin
            case (k % 4)
                0, 2: xact($sformatf("s%0d_i", k), 1'b0, 1'b0, 12'(12'h400 + k), 16'h0000);
                1:    xact($sformatf("s%0d_dld", k), 1'b1, 1'b0, 12'(12'h500 + k), 16'h0000);
                default: xact($sformatf("s%0d_dst", k), 1'b1, 1'b1, 12'(12'h600 + k), 16'(16'hBE00 + k));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
